// File: rtl/kros_pkg.sv
// Shared constants and helpers for the LED sequencer: pattern indices, frequency limits,
// seven-segment codes (active-low gfedcba) and pattern initial values.
package kros_pkg;

    localparam logic [1:0] SEQ_KNIGHT = 2'd0;
    localparam logic [1:0] SEQ_ROTATE = 2'd1;
    localparam logic [1:0] SEQ_BAR    = 2'd2;
    localparam logic [1:0] SEQ_ALT    = 2'd3;

    localparam logic [3:0] FREQ_MIN = 4'd1;
    localparam logic [3:0] FREQ_MAX = 4'd8;
    localparam logic [3:0] FREQ_RST = 4'd4;

    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_S     = 7'h12;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [9:0] LED_ALT_A = 10'h155;
    localparam logic [9:0] LED_ALT_B = 10'h2AA;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [9:0] pattern_init(input logic [1:0] seq);
        logic [9:0] led;
        case (seq)
            SEQ_KNIGHT: led = 10'h001;
            SEQ_ROTATE: led = 10'h001;
            SEQ_BAR:    led = 10'h000;
            default:    led = LED_ALT_A;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stability debouncer and a
// one-cycle press pulse on the debounced 1->0 transition.
module pb_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pb_ni,
    output logic press_o
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            level_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts consecutive samples that disagree with the accepted level; any agreeing
    // sample restarts the count, so short glitches never reach the threshold.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= pb_ni;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press_o = level_prev_q & ~level_q;

endmodule

// File: rtl/kros_led_sequencer.sv
// Top-level LED pattern generator: four debounced buttons select step rate and pattern,
// LEDR animates the selected pattern, HEX displays show level and pattern index.
module kros_led_sequencer
    import kros_pkg::*;
#(
    parameter int unsigned BASE_DIV   = 4,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       pb_freq_up,
    input  logic       pb_freq_dn,
    input  logic       pb_seq_up,
    input  logic       pb_seq_dn,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    logic        ev_freq_up, ev_freq_dn, ev_seq_up, ev_seq_dn;
    logic [3:0]  freq_q, freq_d;
    logic [1:0]  seq_q, seq_d;
    logic [31:0] div_q, div_d;
    logic [9:0]  led_q, led_d;
    logic        dir_q, dir_d;
    logic [31:0] period;
    logic        step;
    logic        freq_chg, seq_chg;

    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_freq_up (
        .clk_i(CLK_50), .rst_ni(reset), .pb_ni(pb_freq_up), .press_o(ev_freq_up)
    );
    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_freq_dn (
        .clk_i(CLK_50), .rst_ni(reset), .pb_ni(pb_freq_dn), .press_o(ev_freq_dn)
    );
    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_seq_up (
        .clk_i(CLK_50), .rst_ni(reset), .pb_ni(pb_seq_up), .press_o(ev_seq_up)
    );
    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_seq_dn (
        .clk_i(CLK_50), .rst_ni(reset), .pb_ni(pb_seq_dn), .press_o(ev_seq_dn)
    );

    assign period = BASE_DIV << (FREQ_MAX - freq_q);
    assign step   = (div_q == period - 32'd1);

    always_comb begin
        freq_d = freq_q;
        if (ev_freq_up && !ev_freq_dn && freq_q != FREQ_MAX) begin
            freq_d = freq_q + 4'd1;
        end else if (ev_freq_dn && !ev_freq_up && freq_q != FREQ_MIN) begin
            freq_d = freq_q - 4'd1;
        end
        freq_chg = (freq_d != freq_q);

        seq_d = seq_q;
        if (ev_seq_up && !ev_seq_dn) begin
            seq_d = seq_q + 2'd1;
        end else if (ev_seq_dn && !ev_seq_up) begin
            seq_d = seq_q - 2'd1;
        end
        seq_chg = (seq_d != seq_q);

        div_d = (freq_chg || seq_chg || step) ? 32'd0 : div_q + 32'd1;

        led_d = led_q;
        dir_d = dir_q;
        if (seq_chg) begin
            led_d = pattern_init(seq_d);
            dir_d = 1'b1;
        end else if (step) begin
            unique case (seq_q)
                SEQ_KNIGHT: begin
                    // dir_q = 1 moves toward bit 9; each end turns the dot around.
                    if (dir_q) begin
                        if (led_q[9]) begin
                            led_d = 10'h100;
                            dir_d = 1'b0;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d = 10'h002;
                            dir_d = 1'b1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                SEQ_ROTATE: led_d = {led_q[8:0], led_q[9]};
                SEQ_BAR:    led_d = (led_q == 10'h3FF) ? 10'h000 : {led_q[8:0], 1'b1};
                SEQ_ALT:    led_d = (led_q == LED_ALT_A) ? LED_ALT_B : LED_ALT_A;
            endcase
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!reset) begin
            freq_q <= FREQ_RST;
            seq_q  <= SEQ_KNIGHT;
            div_q  <= 32'd0;
            led_q  <= pattern_init(SEQ_KNIGHT);
            dir_q  <= 1'b1;
        end else begin
            freq_q <= freq_d;
            seq_q  <= seq_d;
            div_q  <= div_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
        end
    end

    assign LEDR = led_q;
    assign HEX0 = seg_digit(freq_q);
    assign HEX1 = SEG_F;
    assign HEX2 = seg_digit({2'b00, seq_q});
    assign HEX3 = SEG_S;
    assign HEX4 = SEG_BLANK;
    assign HEX5 = SEG_BLANK;

endmodule

// File: tb/tb_kros_led_sequencer.sv
// Bench for kros_led_sequencer: directed and random button activity against a model that
// derives LEDR from a step count per pattern and tracks rate/pattern from press timing.
module tb_kros_led_sequencer;

    localparam int BASE = 4;
    localparam int DEB  = 16;
    // Press takes effect at the edge where the raw button has been low this many edges.
    localparam int LAT  = DEB + 3;

    logic       CLK_50 = 1'b0;
    logic       reset  = 1'b0;
    logic [3:0] pb     = 4'hF;  // 0 freq_up, 1 freq_dn, 2 seq_up, 3 seq_dn
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_cmp = 0;
    int n_bad = 0;

    int m_level, m_seq, m_div, m_phase;
    int run [4];

    logic [6:0] seg_tab [0:8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                  7'h78, 7'h00};

    kros_led_sequencer #(.BASE_DIV(BASE), .DEB_CYCLES(DEB)) dut (
        .CLK_50(CLK_50), .reset(reset),
        .pb_freq_up(pb[0]), .pb_freq_dn(pb[1]), .pb_seq_up(pb[2]), .pb_seq_dn(pb[3]),
        .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4),
        .HEX5(HEX5)
    );

    always #10 CLK_50 = ~CLK_50;

    function automatic logic [9:0] exp_led(input int seq, input int phase);
        int p;
        case (seq)
            0: begin
                p = phase % 18;
                return (p < 10) ? 10'(1 << p) : 10'(1 << (18 - p));
            end
            1: return 10'(1 << (phase % 10));
            2: return 10'((1 << (phase % 11)) - 1);
            default: return (phase % 2 == 0) ? 10'h155 : 10'h2AA;
        endcase
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ev [4];
        bit step;
        int new_level, new_seq;
        if (!reset) begin
            m_level = 4; m_seq = 0; m_div = 0; m_phase = 0;
            foreach (run[i]) run[i] = 0;
            return;
        end
        foreach (run[i]) begin
            run[i] = pb[i] ? 0 : run[i] + 1;
            ev[i]  = (run[i] == LAT);
        end
        step      = (m_div == (BASE << (8 - m_level)) - 1);
        new_level = m_level;
        if (ev[0] && !ev[1]) new_level = (m_level < 8) ? m_level + 1 : 8;
        if (ev[1] && !ev[0]) new_level = (m_level > 1) ? m_level - 1 : 1;
        new_seq = m_seq;
        if (ev[2] && !ev[3]) new_seq = (m_seq + 1) % 4;
        if (ev[3] && !ev[2]) new_seq = (m_seq + 3) % 4;
        if (new_level != m_level || new_seq != m_seq || step) m_div = 0;
        else m_div++;
        if (new_seq != m_seq) m_phase = 0;
        else if (step) m_phase++;
        m_level = new_level;
        m_seq   = new_seq;
    endtask

    task automatic tick();
        @(posedge CLK_50);
        model_edge();
        #1;
        check("ledr", LEDR, exp_led(m_seq, m_phase));
        check("hex0", 10'(HEX0), 10'(seg_tab[m_level]));
        check("hex2", 10'(HEX2), 10'(seg_tab[m_seq]));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [3:0] mask, input int len, input int gap);
        pb = ~mask;
        run_cycles(len);
        pb = 4'hF;
        run_cycles(gap);
    endtask

    task automatic check_static();
        check("hex1", 10'(HEX1), 10'h00E);
        check("hex3", 10'(HEX3), 10'h012);
        check("hex4", 10'(HEX4), 10'h07F);
        check("hex5", 10'(HEX5), 10'h07F);
    endtask

    initial begin
        logic [3:0] mask;
        int len;

        // Reset and default animation
        run_cycles(3);
        check("rst_ledr", LEDR, 10'h001);
        check("rst_hex0", 10'(HEX0), 10'h019);
        check("rst_hex2", 10'(HEX2), 10'h040);
        check_static();
        reset = 1'b1;
        run_cycles(64 * 12);

        // Long hold gives one pattern change; second press reaches bar fill
        press(4'b0100, 500, 200);
        check("seq1_hex2", 10'(HEX2), 10'h079);
        press(4'b0100, 40, 64 * 13);

        // Rate saturation both ways
        for (int i = 0; i < 5; i++) press(4'b0001, 30, 30);
        check("lvl8_hex0", 10'(HEX0), 10'h000);
        run_cycles(100);
        for (int i = 0; i < 8; i++) press(4'b0010, 30, 30);
        check("lvl1_hex0", 10'(HEX0), 10'h079);
        run_cycles(512 * 4);
        for (int i = 0; i < 3; i++) press(4'b0001, 30, 30);

        // Backward wrap into the alternate pattern
        for (int i = 0; i < 3; i++) press(4'b1000, 30, 40);
        check("seq3_hex2", 10'(HEX2), 10'h030);
        run_cycles(300);

        // Glitch and simultaneous presses must not change anything
        press(4'b0001, 5, 60);
        press(4'b1100, 40, 200);

        // Random activity
        for (int i = 0; i < 30; i++) begin
            mask = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) mask |= 4'(1 << $urandom_range(0, 3));
            len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(25, 80);
            press(mask, len, $urandom_range(30, 300));
        end
        check_static();

        // Reach seq 2 / level 7, then reset mid-pattern
        for (int i = 0; i < 4 && m_seq != 2; i++) press(4'b0100, 30, 40);
        for (int i = 0; i < 8 && m_level < 7; i++) press(4'b0001, 30, 40);
        for (int i = 0; i < 8 && m_level > 7; i++) press(4'b0010, 30, 40);
        check("pre_rst_hex2", 10'(HEX2), 10'h024);
        check("pre_rst_hex0", 10'(HEX0), 10'h078);
        run_cycles(37);
        reset = 1'b0;
        tick();
        check("mid_rst_ledr", LEDR, 10'h001);
        check("mid_rst_hex0", 10'(HEX0), 10'h019);
        check("mid_rst_hex2", 10'(HEX2), 10'h040);
        reset = 1'b1;
        run_cycles(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kros_led_sequencer.md
Name: kros_led_sequencer

Overview:
- Top-level LED pattern generator for the DE-class board: animates a 10-LED pattern on LEDR at a selectable rate.
- Four pushbuttons (active-low) adjust the step rate and select among four patterns.
- Status appears on active-low seven-segment displays.
- Single clock domain: CLK_50, 50 MHz.

Parameters:
- BASE_DIV, default 4: base divider in CLK_50 cycles; step period = BASE_DIV << (8 - freq_level). Synthesis value 390625.
- DEB_CYCLES, default 16: consecutive stable synchronized samples required to accept a button level change.

Ports:
- CLK_50  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on CLK_50 rising edge).
- pb_freq_up  in  1  active-low button, raise rate.
- pb_freq_dn  in  1  active-low button, lower rate.
- pb_seq_up  in  1  active-low button, next pattern.
- pb_seq_dn  in  1  active-low button, previous pattern.
- LEDR  out  10  pattern output, 1 = LED on.
- HEX0  out  7  frequency level digit, segments gfedcba, active-low.
- HEX1  out  7  letter 'F' (7'h0E).
- HEX2  out  7  pattern index digit.
- HEX3  out  7  letter 'S' (7'h12).
- HEX4  out  7  blank (7'h7F).
- HEX5  out  7  blank (7'h7F).

Behaviour:
- Reset state: freq_level = 4; seq_idx = 0; divider = 0; pattern = seq0 initial (LEDR = 10'h001).
  - Button press flags clear; debounced levels = released (1).
  - Outputs after reset: HEX0 = 7'h19, HEX2 = 7'h40.
- Button path, each button:
  - 2-FF synchronizer feeds the debouncer.
  - Debounced level changes only after DEB_CYCLES identical consecutive samples.
  - A press event is a 1-cycle pulse on the debounced 1->0 transition.
  - Holding a button produces exactly one event; release produces none.
- Frequency control:
  - freq_level ranges 1..8.
  - up event: +1, saturates at 8. dn event: -1, saturates at 1.
  - up and dn in the same cycle: no change.
  - Any level change clears the divider.
- Step timing:
  - Divider counts 0..P-1, where P = BASE_DIV << (8 - freq_level). At defaults, level 4 gives P = 64.
  - A step pulse fires in the cycle the divider equals P-1; the divider then wraps to 0.
  - LEDR updates on the clock edge after the step pulse.
- Pattern select:
  - seq_idx ranges 0..3.
  - up event: +1, wraps 3->0. dn event: -1, wraps 0->3.
  - Simultaneous up and dn: ignored.
  - On a change: the pattern register loads the new pattern's initial value on the next edge, and the divider clears.
- Patterns, advancing on each step pulse:
  - seq0, Knight Rider: one lit LED. Initial 10'h001, direction left. Shifts toward bit 9, reverses at bit 9, then reverses again at bit 0. Period 18 steps: 001,002,...,200,100,...,002,001,...
  - seq1, rotate: initial 10'h001, rotate left, bit 9 wraps to bit 0. Period 10.
  - seq2, bar fill: initial 10'h000. Each step becomes {LEDR[8:0],1}. From 10'h3FF the next step gives 10'h000. Period 11.
  - seq3, alternate: initial 10'h155, toggles 10'h155 <-> 10'h2AA each step.
- Digit encoding, active-low gfedcba:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00.
- HEX outputs are combinational from registered state.
- Reset mid-operation: all state returns to reset values on the next edge. No partial-pattern retention.

Decomposition:
- Package kros_pkg contains:
  - pattern index constants SEQ_KNIGHT = 0, SEQ_ROTATE = 1, SEQ_BAR = 2, SEQ_ALT = 3;
  - FREQ_MIN = 1, FREQ_MAX = 8, FREQ_RST = 4;
  - seven-segment constants and a digit-to-segment function.
- Sub-module pb_debounce (parameter DEB_CYCLES): synchronizer, debouncer and press-pulse edge detector, instantiated four times.

Test Plan:
- Reset, then release (defaults): LEDR = 001, then steps every 64 CLK_50 cycles through 002, 004, ... 200, 100 (bounce). HEX0 = 19, HEX1 = 0E, HEX2 = 40, HEX3 = 12, HEX4 = HEX5 = 7F.
- Hold pb_seq_up low for 500 cycles: exactly one change, seq_idx = 1, HEX2 = 79, LEDR restarts at 001 and rotates left. A second press gives seq 2: LEDR 000, 001, 003, ... 3FF, 000.
- pb_freq_up pressed 5 times: level saturates at 8, HEX0 = 00, step period = 4 cycles. pb_freq_dn pressed 8 times: level 1, HEX0 = 79, period 512.
- Press pb_seq_dn from seq 0: wraps to seq 3, HEX2 = 30, LEDR alternates 155 / 2AA.
- Glitch pulse of 5 cycles on pb_freq_up (shorter than DEB_CYCLES): no level change. pb_seq_up and pb_seq_dn pressed in the same cycle: seq_idx unchanged.
- Assert reset (0) mid-pattern at seq 2, level 7: on the next edge LEDR = 001, level 4, seq 0.
